// File: rtl/sopc_data_bus_pkg.sv
// sopc_data_bus_pkg: shared bus widths, FSM state encoding and index-width helper
package sopc_data_bus_pkg;
   localparam int REG_W = 32;
   localparam int SEL_W = 4;
   typedef enum logic [1:0] {
      BUS_IDLE = 2'd0,
      BUS_BUSY = 2'd1,
      BUS_DONE = 2'd2,
      BUS_ERR  = 2'd3
   } bus_state_t;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sopc_data_bus_addr_decode.sv
// sopc_data_bus_addr_decode: base/mask address decoder, lowest matching slave index wins
// addr in 32; hit out 1 (any slave matched); idx out (index of lowest matching slave)
module sopc_data_bus_addr_decode
   import sopc_data_bus_pkg::*;
#(
   parameter int                      NUM_SLAVES = 2,
   parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {32'hFFFF_F000, 32'hFFFF_0000},
   parameter int                      IW         = idx_width(NUM_SLAVES)
) (
   input  logic [REG_W-1:0] addr,
   output logic             hit,
   output logic [IW-1:0]    idx
);
   // scanning high to low lets the lowest matching index overwrite the result
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--)
         if ((addr & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]) begin
            hit = 1'b1;
            idx = IW'(k);
         end
   end
endmodule

// File: rtl/sopc_data_bus.sv
// sopc_data_bus: one data master to NUM_SLAVES slaves with decode, ack handshake, stall, timeout and error
// master side: m_ce_i/m_we_i/m_addr_i/m_sel_i/m_data_i in, m_data_o/m_stall_o/m_err_o out
// slave side: s_ce_o (one-hot), s_we_o/s_addr_o/s_sel_o/s_data_o (registered) out, s_data_i/s_ack_i in
module sopc_data_bus
   import sopc_data_bus_pkg::*;
#(
   parameter int                      NUM_SLAVES = 2,
   parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {32'hFFFF_F000, 32'hFFFF_0000},
   parameter int                      TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m_ce_i,
   input  logic                    m_we_i,
   input  logic [REG_W-1:0]        m_addr_i,
   input  logic [SEL_W-1:0]        m_sel_i,
   input  logic [REG_W-1:0]        m_data_i,
   output logic [REG_W-1:0]        m_data_o,
   output logic                    m_stall_o,
   output logic                    m_err_o,
   output logic [NUM_SLAVES-1:0]   s_ce_o,
   output logic                    s_we_o,
   output logic [REG_W-1:0]        s_addr_o,
   output logic [SEL_W-1:0]        s_sel_o,
   output logic [REG_W-1:0]        s_data_o,
   input  logic [NUM_SLAVES*32-1:0] s_data_i,
   input  logic [NUM_SLAVES-1:0]   s_ack_i
);
   localparam int IW = idx_width(NUM_SLAVES);
   localparam int TW = $clog2(TIMEOUT + 1);
   bus_state_t            st;
   logic [IW-1:0]         idx;
   logic [TW-1:0]         cnt;
   logic                  dec_hit;
   logic [IW-1:0]         dec_idx;
   logic [NUM_SLAVES-1:0] one;
   sopc_data_bus_addr_decode #(
      .NUM_SLAVES(NUM_SLAVES),
      .SLV_BASE  (SLV_BASE),
      .SLV_MASK  (SLV_MASK),
      .IW        (IW)
   ) u_dec (
      .addr(m_addr_i),
      .hit (dec_hit),
      .idx (dec_idx)
   );
   // stall must rise in the request cycle itself so the core never advances past an unfinished access
   always_comb begin
      one       = NUM_SLAVES'(1);
      m_stall_o = (st == BUS_BUSY) || (st == BUS_IDLE && m_ce_i);
      m_err_o   = st == BUS_ERR;
      s_ce_o    = (st == BUS_BUSY) ? one << idx : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= BUS_IDLE;
         idx      <= '0;
         cnt      <= '0;
         s_we_o   <= 1'b0;
         s_addr_o <= '0;
         s_sel_o  <= '0;
         s_data_o <= '0;
         m_data_o <= '0;
      end else begin
         case (st)
            BUS_IDLE:
               if (m_ce_i) begin
                  s_we_o   <= m_we_i;
                  s_addr_o <= m_addr_i;
                  s_sel_o  <= m_sel_i;
                  s_data_o <= m_data_i;
                  idx      <= dec_idx;
                  cnt      <= '0;
                  st       <= dec_hit ? BUS_BUSY : BUS_ERR;
                  if (!dec_hit) m_data_o <= '0;
               end
            // ack is tested before the timeout so a last-cycle ack still completes
            BUS_BUSY:
               if (s_ack_i[idx]) begin
                  st       <= BUS_DONE;
                  m_data_o <= s_we_o ? '0 : s_data_i[idx*REG_W +: REG_W];
               end else if (cnt == TW'(TIMEOUT - 1)) begin
                  st       <= BUS_ERR;
                  m_data_o <= '0;
               end else
                  cnt <= cnt + 1'b1;
            BUS_DONE: st <= BUS_IDLE;
            BUS_ERR:  st <= BUS_IDLE;
         endcase
      end
   end
endmodule
